lp805x_sfr_pxfer: RTL and testbench

//  Peripheral-clock-side SFR transfer engine: the stage that drives lp805x_synctrl's
//  sfr_prrdy/sfr_pwrdy/read and consumes its sfr_pget/sfr_pput.

---
 rtl/lp805x_sfr_pxfer.sv | 110 +++++++++++
 tb/tb_lp805x_sfr_pxfer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lp805x_sfr_pxfer.sv
// lp805x_sfr_pxfer: peripheral-clock SFR transfer engine (toggle request in, one bus access, toggle ack out)
// Optional p_ready timeout enabled by defining LP805X_SFR_TIMEOUT_EN.
module lp805x_sfr_pxfer #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int SYNC    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_tgl,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          ack_tgl,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          sfr_prrdy,
  input  logic          sfr_pget,
  output logic          sfr_pwrdy,
  output logic          read,
  input  logic          sfr_pput,
  output logic          p_sel,
  output logic          p_we,
  output logic [AW-1:0] p_addr,
  output logic [DW-1:0] p_wdata,
  input  logic [DW-1:0] p_rdata,
  input  logic          p_ready
);
  typedef enum logic [1:0] {IDLE, GRANT, ACCESS, DONE} state_t;
  state_t state;
  logic [SYNC-1:0] sync;
  logic served_tgl;
  logic req_s;
  assign req_s = sync[SYNC-1];
  assign read = sfr_pwrdy;
`ifdef LP805X_SFR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic tmo;
  assign tmo = cnt == CW'(TIMEOUT - 1);
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign rsp_err = 1'b0;
`endif
  // Pending is a level compare so a toggle arriving while busy waits for IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sync       <= '0;
      served_tgl <= 1'b0;
      ack_tgl    <= 1'b0;
      rsp_rdata  <= '0;
      sfr_prrdy  <= 1'b0;
      sfr_pwrdy  <= 1'b0;
      p_sel      <= 1'b0;
      p_we       <= 1'b0;
      p_addr     <= '0;
      p_wdata    <= '0;
`ifdef LP805X_SFR_TIMEOUT_EN
      rsp_err    <= 1'b0;
      cnt        <= '0;
`endif
    end else begin
      sync      <= {sync[SYNC-2:0], req_tgl};
      sfr_prrdy <= 1'b0;
      case (state)
        IDLE: if (req_s != served_tgl) begin
          p_we       <= req_wr;
          p_addr     <= req_addr;
          p_wdata    <= req_wdata;
          served_tgl <= req_s;
          sfr_prrdy  <= 1'b1;
          state      <= GRANT;
        end
        GRANT: if (sfr_pget) begin
          p_sel <= 1'b1;
          state <= ACCESS;
`ifdef LP805X_SFR_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        ACCESS: if (p_ready) begin
          p_sel     <= 1'b0;
          rsp_rdata <= p_we ? rsp_rdata : p_rdata;
          sfr_pwrdy <= 1'b1;
          state     <= DONE;
`ifdef LP805X_SFR_TIMEOUT_EN
          rsp_err   <= 1'b0;
        end else if (tmo) begin
          p_sel     <= 1'b0;
          rsp_rdata <= p_we ? rsp_rdata : {DW{1'b1}};
          rsp_err   <= 1'b1;
          sfr_pwrdy <= 1'b1;
          state     <= DONE;
        end else begin
          cnt <= cnt + 1'b1;
`endif
        end
        DONE: if (sfr_pput) begin
          sfr_pwrdy <= 1'b0;
          ack_tgl   <= ~ack_tgl;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lp805x_sfr_pxfer.sv
// tb_lp805x_sfr_pxfer: scoreboard bench; stimulus pushes expected responses, a monitor checks each ack toggle.
module tb_lp805x_sfr_pxfer;
  logic clk, rst;
  logic req_tgl, req_wr;
  logic [7:0] req_addr, req_wdata;
  logic ack_tgl, rsp_err, sfr_prrdy, sfr_pwrdy, read, p_sel, p_we;
  logic [7:0] rsp_rdata, p_addr, p_wdata, p_rdata;
  logic sfr_pget, sfr_pput, p_ready;

  lp805x_sfr_pxfer #(.AW(8), .DW(8), .SYNC(2), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req_tgl(req_tgl), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack_tgl(ack_tgl), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sfr_prrdy(sfr_prrdy), .sfr_pget(sfr_pget), .sfr_pwrdy(sfr_pwrdy), .read(read),
    .sfr_pput(sfr_pput), .p_sel(p_sel), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_ready(p_ready)
  );

  typedef struct {
    logic [7:0] rdata;
    logic err;
    int sel;
    int pw;
    logic we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int gap;
  } exp_t;
  exp_t q[$];

  int checks = 0, failures = 0;
  int ready_at = 1, pput_delay = 0, sel_cnt = 0, pw_cnt = 0;
  logic [7:0] rdata_v = 8'h00;
  int cyc = 0, ack_cnt = 0, ack_cyc = -100, gap_v = -1;
  int sel_acc = 0, pw_acc = 0, pr_acc = 0;
  logic prev_ack = 1'b0, bus_ok = 1'b1, read_ok = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign sfr_pget = 1'b1;
  assign p_rdata = rdata_v;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  // peripheral: p_ready on the ready_at-th cycle of p_sel; synctrl: pput after pput_delay extra cycles
  initial begin
    p_ready = 1'b0;
    sfr_pput = 1'b0;
    forever begin
      @(posedge clk); #1;
      sel_cnt = p_sel ? sel_cnt + 1 : 0;
      p_ready = p_sel && sel_cnt >= ready_at;
      pw_cnt = sfr_pwrdy ? pw_cnt + 1 : 0;
      sfr_pput = sfr_pwrdy && pw_cnt > pput_delay;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sel_acc = 0; pw_acc = 0; pr_acc = 0; prev_ack = 1'b0;
      bus_ok = 1'b1; read_ok = 1'b1; gap_v = -1; ack_cyc = -100;
    end else begin
      cyc++;
      if (read !== sfr_pwrdy) read_ok = 1'b0;
      if (sfr_prrdy) begin
        pr_acc++;
        gap_v = cyc - ack_cyc;
      end
      if (p_sel) begin
        sel_acc++;
        if (q.size() == 0) bus_ok = 1'b0;
        else if (p_we !== q[0].we || p_addr !== q[0].addr || (p_we && p_wdata !== q[0].wdata)) bus_ok = 1'b0;
      end
      if (sfr_pwrdy) pw_acc++;
      if (ack_tgl !== prev_ack) begin
        prev_ack = ack_tgl;
        ack_cnt++;
        ack_cyc = cyc;
        if (q.size() == 0) chk("unexpected_ack", 32'(ack_cnt), 32'(ack_cnt - 1));
        else begin
          e = q.pop_front();
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("p_sel_cycles", 32'(sel_acc), 32'(e.sel));
          chk("pwrdy_cycles", 32'(pw_acc), 32'(e.pw));
          chk("prrdy_pulses", 32'(pr_acc), 32'd1);
          chk("bus_fields", 32'(bus_ok), 32'd1);
          chk("read_eq_pwrdy", 32'(read_ok), 32'd1);
          if (e.gap >= 0) chk("restart_gap", 32'(gap_v), 32'(e.gap));
        end
        sel_acc = 0; pw_acc = 0; pr_acc = 0; bus_ok = 1'b1; read_ok = 1'b1;
      end
    end
  end

  task automatic push(input logic [7:0] rd, input logic er, input int sel, input int pw,
                      input logic we, input logic [7:0] a, input logic [7:0] wd, input int gap);
    exp_t e;
    e.rdata = rd; e.err = er; e.sel = sel; e.pw = pw; e.we = we; e.addr = a; e.wdata = wd; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d);
    req_wr = wr; req_addr = a; req_wdata = d; req_tgl = ~req_tgl;
  endtask

  task automatic wait_acks(input int n);
    int t = 0;
    while (ack_cnt < n && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ack_count", 32'(ack_cnt), 32'(n));
  endtask

  task automatic wait_sel();
    int t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!p_sel && t < 100);
    chk("p_sel_seen", 32'(p_sel), 32'd1);
  endtask

  initial begin
    int ac;
    rst = 1'b1; req_tgl = 1'b0; req_wr = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack_tgl", 32'(ack_tgl), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_prrdy", 32'(sfr_prrdy), 32'd0);
    chk("rst_pwrdy", 32'(sfr_pwrdy), 32'd0);
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_p_sel", 32'(p_sel), 32'd0);
    chk("rst_p_we", 32'(p_we), 32'd0);
    chk("rst_p_addr", 32'(p_addr), 32'd0);
    chk("rst_p_wdata", 32'(p_wdata), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    ready_at = 2; rdata_v = 8'h5A;
    push(8'h5A, 1'b0, 2, 1, 1'b0, 8'h81, 8'h00, -1);
    issue(1'b0, 8'h81, 8'h00);
    wait_acks(1);
    ready_at = 1; rdata_v = 8'h11;
    push(8'h5A, 1'b0, 1, 1, 1'b1, 8'h90, 8'hC3, -1);
    issue(1'b1, 8'h90, 8'hC3);
    wait_acks(2);
    ready_at = 4; rdata_v = 8'h3C;
    push(8'h3C, 1'b0, 4, 1, 1'b0, 8'hA0, 8'h00, -1);
    issue(1'b0, 8'hA0, 8'h00);
    wait_sel();
    req_tgl = ~req_tgl;
    @(posedge clk); #1;
    req_tgl = ~req_tgl;
    wait_acks(3);
    repeat (20) @(posedge clk); #1;
    chk("no_second_ack", 32'(ack_cnt), 32'd3);
    chk("no_second_prrdy", 32'(pr_acc), 32'd0);
    ready_at = 2; rdata_v = 8'h77;
    push(8'h77, 1'b0, 2, 1, 1'b0, 8'hA1, 8'h00, -1);
    push(8'h77, 1'b0, 2, 1, 1'b0, 8'hA1, 8'h00, 1);
    issue(1'b0, 8'hA1, 8'h00);
    wait_sel();
    req_tgl = ~req_tgl;
    wait_acks(5);
    ready_at = 1; rdata_v = 8'h0F; pput_delay = 6;
    push(8'h0F, 1'b0, 1, 7, 1'b0, 8'h82, 8'h00, -1);
    issue(1'b0, 8'h82, 8'h00);
    wait_acks(6);
    pput_delay = 0;
    ready_at = 1000; rdata_v = 8'hEE;
    issue(1'b0, 8'h83, 8'h00);
    wait_sel();
    rst = 1'b1; req_tgl = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ac = ack_cnt;
    @(negedge clk);
    chk("abort_p_sel", 32'(p_sel), 32'd0);
    chk("abort_ack_tgl", 32'(ack_tgl), 32'd0);
    chk("abort_pwrdy", 32'(sfr_pwrdy), 32'd0);
    repeat (10) @(posedge clk); #1;
    chk("abort_no_ack", 32'(ack_cnt), 32'(ac));
    chk("abort_no_restart", 32'(pr_acc), 32'd0);
`ifdef LP805X_SFR_TIMEOUT_EN
    rdata_v = 8'h44;
    push(8'hFF, 1'b1, 15, 1, 1'b0, 8'h84, 8'h00, -1);
    issue(1'b0, 8'h84, 8'h00);
    wait_acks(ac + 1);
    ready_at = 1; rdata_v = 8'h21;
    push(8'h21, 1'b0, 1, 1, 1'b0, 8'h85, 8'h00, -1);
    issue(1'b0, 8'h85, 8'h00);
    wait_acks(ac + 2);
`endif
    ready_at = 1;
    repeat (5) @(posedge clk); #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
